// File: rtl/pq_mem_pkg.sv
// pq_mem_pkg: shared FSM state type and parameter legality helper for the pipelined RAM.
package pq_mem_pkg;
    typedef enum logic {CLEAR, RUN} state_t;
    function automatic bit legal_latency(int l);
        return l == 1 || l == 2;
    endfunction
endpackage

// File: rtl/sdp_ram_core.sv
// sdp_ram_core: one-clock simple-dual-port storage, byte-enable write, registered read.
module sdp_ram_core #(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_DEPTH = 1024,
    parameter int AW = $clog2(MEM_DEPTH)
) (
    input  logic                   clock,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [MEM_WIDTH/8-1:0] be,
    input  logic [MEM_WIDTH-1:0]   wdata,
    input  logic                   re,
    input  logic [AW-1:0]          raddr,
    output logic [MEM_WIDTH-1:0]   rdata
);
    logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];
    always_ff @(posedge clock) begin
        if (we)
            for (int i = 0; i < MEM_WIDTH/8; i++)
                if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/simple_dual_pipe_ram.sv
// simple_dual_pipe_ram: simple-dual-port RAM with zero-fill after reset,
// optional write-first collision bypass and a 1- or 2-cycle read pipeline.
module simple_dual_pipe_ram
    import pq_mem_pkg::*;
#(
    parameter int MEM_WIDTH      = 32,
    parameter int MEM_DEPTH      = 1024,
    parameter int READ_LATENCY   = 1,
    parameter int BYPASS_EN      = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         en_a,
    input  logic                         write_en_a,
    input  logic [MEM_WIDTH/8-1:0]       byte_en_a,
    input  logic [$clog2(MEM_DEPTH)-1:0] addr_a,
    input  logic [MEM_WIDTH-1:0]         data_in_a,
    input  logic                         en_b,
    input  logic [$clog2(MEM_DEPTH)-1:0] addr_b,
    output logic [MEM_WIDTH-1:0]         data_out_b,
    output logic                         valid_b,
    output logic                         ready
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int NB = MEM_WIDTH / 8;
    localparam logic [AW:0] DEPTH = (AW+1)'(MEM_DEPTH);

    if (!legal_latency(READ_LATENCY) || MEM_WIDTH % 8 != 0) begin : g_bad
        $fatal(1, "simple_dual_pipe_ram: READ_LATENCY must be 1 or 2 and MEM_WIDTH a multiple of 8");
    end

    state_t state, state_nx;
    logic [AW-1:0] cnt, core_addr;
    logic clearing, a_ok, b_ok, wr, rd, coll, core_we, v1, ok1;
    logic [NB-1:0] core_be, m1;
    logic [MEM_WIDTH-1:0] core_wd, rdata, wd1, dat1;

    always_comb begin
        clearing  = state == CLEAR;
        ready     = state == RUN;
        a_ok      = {1'b0, addr_a} < DEPTH;
        b_ok      = {1'b0, addr_b} < DEPTH;
        wr        = ready && en_a && write_en_a && a_ok;
        rd        = ready && en_b;
        coll      = BYPASS_EN != 0 && wr && rd && addr_a == addr_b;
        state_nx  = (clearing && cnt == AW'(MEM_DEPTH - 1)) ? RUN : state;
        core_we   = clearing || wr;
        core_addr = clearing ? cnt : addr_a;
        core_be   = clearing ? '1 : byte_en_a;
        core_wd   = clearing ? '0 : data_in_a;
    end

    sdp_ram_core #(.MEM_WIDTH(MEM_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_core (
        .clock(clock),
        .we(core_we),
        .waddr(core_addr),
        .be(core_be),
        .wdata(core_wd),
        .re(rd && b_ok),
        .raddr(addr_b),
        .rdata(rdata)
    );

    // Stage-1 side info: range flag and the bytes to overlay from a colliding write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLEAR_ON_RESET != 0 ? CLEAR : RUN;
            cnt   <= '0;
            v1    <= 1'b0;
            ok1   <= 1'b0;
            m1    <= '0;
            wd1   <= '0;
        end else begin
            state <= state_nx;
            if (clearing) cnt <= cnt + 1'b1;
            v1 <= rd;
            if (rd) begin
                ok1 <= b_ok;
                m1  <= coll ? byte_en_a : '0;
                wd1 <= data_in_a;
            end
        end
    end

    always_comb begin
        dat1 = '0;
        for (int i = 0; i < NB; i++)
            dat1[8*i +: 8] = ok1 ? (m1[i] ? wd1[8*i +: 8] : rdata[8*i +: 8]) : 8'h00;
    end

    if (READ_LATENCY == 2) begin : g_l2
        logic v2;
        logic [MEM_WIDTH-1:0] d2;
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                v2 <= 1'b0;
                d2 <= '0;
            end else begin
                v2 <= v1;
                if (v1) d2 <= dat1;
            end
        end
        assign valid_b    = v2;
        assign data_out_b = d2;
    end else begin : g_l1
        assign valid_b    = v1;
        assign data_out_b = dat1;
    end
endmodule

// File: doc/simple_dual_pipe_ram.md
SIMPLE_DUAL_PIPE_RAM -- requirements
Module: simple_dual_pipe_ram

Interface
REQ-001 SHALL have parameter MEM_WIDTH, default 32: data width in bits, a multiple of 8.
REQ-002 SHALL have parameter MEM_DEPTH, default 1024: number of words, any value >= 2 (power of two not required).
REQ-003 SHALL have parameter READ_LATENCY, default 1: read latency in cycles; legal values 1 or 2.
REQ-004 SHALL have parameter BYPASS_EN, default 1: 1 = write-first forwarding on same-address collision, 0 = read-old.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1: 1 = zero-fill the whole array after reset.
REQ-006 SHALL have port clock, input, 1: the single clock; all logic on posedge.
REQ-007 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port en_a, input, 1: port A enable.
REQ-009 SHALL have port write_en_a, input, 1: port A write strobe, qualified by en_a.
REQ-010 SHALL have port byte_en_a, input, MEM_WIDTH/8: per-byte write mask.
REQ-011 SHALL have port addr_a, input, $clog2(MEM_DEPTH): write address.
REQ-012 SHALL have port data_in_a, input, MEM_WIDTH: write data.
REQ-013 SHALL have port en_b, input, 1: read request.
REQ-014 SHALL have port addr_b, input, $clog2(MEM_DEPTH): read address.
REQ-015 SHALL have port data_out_b, output, MEM_WIDTH: read data.
REQ-016 SHALL have port valid_b, output, 1: data_out_b carries the result of an accepted read.
REQ-017 SHALL have port ready, output, 1: array initialised; requests are accepted.

Function
REQ-018 A write SHALL occur when en_a && write_en_a && ready && addr_a < MEM_DEPTH, updating only bytes whose byte_en_a bit is 1.
REQ-019 A read SHALL be accepted when en_b && ready; data_out_b and valid_b SHALL appear exactly READ_LATENCY cycles after the accepting edge.
REQ-020 When no read is accepted, valid_b SHALL be 0 at the corresponding cycle, and data_out_b SHALL hold its previous value.
REQ-021 A read with addr_b >= MEM_DEPTH SHALL return all-zero data with valid_b = 1.
REQ-022 When a write and an accepted read hit the same address in the same cycle and BYPASS_EN = 1, the read SHALL return the old word with enabled bytes replaced by data_in_a.
REQ-023 In the same collision with BYPASS_EN = 0, the read SHALL return the pre-write word.
REQ-024 Reads and writes to different addresses in the same cycle SHALL both complete without interaction.
REQ-025 The FSM SHALL have states CLEAR and RUN; with CLEAR_ON_RESET = 1 it SHALL leave reset in CLEAR, otherwise in RUN.
REQ-026 In CLEAR, an internal counter SHALL write zero to address 0..MEM_DEPTH-1, one word per cycle, ignoring en_a/en_b; ready SHALL be 0.
REQ-027 The FSM SHALL go CLEAR -> RUN on the cycle after writing address MEM_DEPTH-1; ready SHALL rise on that same edge, MEM_DEPTH cycles after reset release.
REQ-028 In RUN, ready SHALL be 1, and the FSM SHALL stay in RUN until reset.
REQ-029 Requests presented while ready = 0 SHALL be dropped, not queued.

Reset
REQ-030 Asserting reset_n low SHALL asynchronously force valid_b = 0, data_out_b = 0, pipeline stages = 0, clear counter = 0, and ready = 0 (CLEAR_ON_RESET = 1) or 1 (CLEAR_ON_RESET = 0).
REQ-031 Reset during CLEAR SHALL restart the clear from address 0.
REQ-032 Array contents SHALL NOT be reset asynchronously; with CLEAR_ON_RESET = 0 they SHALL persist across reset.

Structure
REQ-033 The state enum {CLEAR, RUN} and a function checking legal READ_LATENCY SHALL live in the shared package pq_mem_pkg.
REQ-034 The array SHALL be a single sub-module sdp_ram_core: plain one-clock simple-dual-port storage with byte-enable write and 1-cycle registered read, inferable as block RAM.
REQ-035 The bypass merge, the second pipeline stage, the clear FSM and the address-range checks SHALL sit in the top level.
REQ-036 Elaboration SHALL fail when READ_LATENCY is not 1 or 2, or when MEM_WIDTH is not a multiple of 8.

Verification
REQ-037 CLEAR_ON_RESET = 1, MEM_DEPTH = 16: release reset -> ready rises after 16 cycles; reads of addresses 0..15 return 0x00000000.
REQ-038 READ_LATENCY = 2: write 0xDEADBEEF to address 5, then read address 5 -> data_out_b = 0xDEADBEEF with valid_b = 1 exactly 2 cycles after the request.
REQ-039 Address 3 holds 0x11223344; same-cycle write of 0xAABBCCDD with byte_en_a = 4'b0101 and read of address 3 -> BYPASS_EN = 1 returns 0x11BB33DD, BYPASS_EN = 0 returns 0x11223344.
REQ-040 MEM_DEPTH = 12: write to address 13 is dropped; read of address 13 returns 0 with valid_b = 1; addresses 0..11 are unchanged.
REQ-041 Assert reset_n at clear count 7 -> outputs zero immediately; after release, ready rises after a full MEM_DEPTH cycles.
REQ-042 Assert en_b while ready = 0 -> no valid_b pulse; back-to-back reads of addresses 1, 2, 3 in RUN -> three consecutive valid_b cycles, in order.
